ppla_spi_shift_engine: RTL

//  SPI master shift engine downstream of the ppla_spi_repeater AXI4-Lite register slave.

---
 rtl/ppla_spi_shift_engine_if.sv | 27 ++
 rtl/ppla_spi_shift_engine.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ppla_spi_shift_engine_if.sv
// Command/response handshake bundle between the register slave and the SPI shift engine.
interface ppla_spi_shift_engine_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 6,
  parameter int unsigned DIV_WIDTH  = 8
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic [1:0]            cmd_mode;
  logic [DIV_WIDTH-1:0]  cmd_div;
  logic                  cmd_hold;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  busy;

  modport master (
    output cmd_valid, cmd_data, cmd_len, cmd_mode, cmd_div, cmd_hold,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_len, cmd_mode, cmd_div, cmd_hold,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/ppla_spi_shift_engine.sv
// SPI master shift engine: one command in, SCLK/MOSI/CS_N out, one-cycle RX response.
// Optional SPI_LOOPBACK_EN adds a loopback input that samples MOSI instead of MISO.
module ppla_spi_shift_engine #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 6,
  parameter int unsigned DIV_WIDTH  = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  ppla_spi_shift_engine_if.slave  bus,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output logic                    spi_cs_n
`ifdef SPI_LOOPBACK_EN
  ,
  input  logic                    loopback
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;
  state_t state, state_nxt;

  logic [LEN_WIDTH-1:0]  bcnt;
  logic [LEN_WIDTH-1:0]  last_bit;
  logic [DIV_WIDTH-1:0]  hcnt;
  logic [DIV_WIDTH-1:0]  div_q;
  logic [1:0]            mode_q;
  logic                  hold_q;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [DATA_WIDTH-1:0] tx_init;
  logic                  accept;
  logic                  half_end;
  logic                  lead_edge;
  logic                  last_edge;
  logic                  sample_bit;

  assign accept    = bus.cmd_valid && bus.cmd_ready;
  // Terminal count is div itself, so div = all-ones gives H = 2^DIV_WIDTH without overflow.
  assign half_end  = (hcnt == div_q);
  assign lead_edge = (spi_sclk == mode_q[1]);
  assign last_edge = !lead_edge && (bcnt == '0);
  assign last_bit  = (bus.cmd_len == '0) ? LEN_WIDTH'(DATA_WIDTH - 1) : bus.cmd_len - 1'b1;
  assign tx_init   = bus.cmd_data << (LEN_WIDTH'(DATA_WIDTH - 1) - last_bit);

`ifdef SPI_LOOPBACK_EN
  logic loop_q;

  always_ff @(posedge clock) begin
    if (reset)       loop_q <= 1'b0;
    else if (accept) loop_q <= loopback;
  end

  assign sample_bit = loop_q ? spi_mosi : spi_miso;
`else
  assign sample_bit = spi_miso;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   if (half_end) state_nxt = SHIFT;
      SHIFT:   if (half_end && last_edge) state_nxt = HOLD;
      HOLD:    if (half_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.busy      = 1'b1;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = '0;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = !reset;
        bus.busy      = 1'b0;
      end
      DONE: begin
        bus.rsp_valid = !reset;
        bus.rsp_data  = rx_sr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
      hcnt     <= '0;
      bcnt     <= '0;
      div_q    <= '0;
      mode_q   <= '0;
      hold_q   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
    end else begin
      hcnt <= half_end ? '0 : hcnt + 1'b1;
      unique case (state)
        IDLE: begin
          hcnt <= '0;
          if (spi_cs_n) spi_sclk <= mode_q[1];
          if (accept) begin
            div_q    <= bus.cmd_div;
            mode_q   <= bus.cmd_mode;
            hold_q   <= bus.cmd_hold;
            bcnt     <= last_bit;
            rx_sr    <= '0;
            spi_cs_n <= 1'b0;
            spi_sclk <= bus.cmd_mode[1];
            // CPHA=0 presents the first bit during SETUP; CPHA=1 waits for the leading edge.
            if (!bus.cmd_mode[0]) begin
              spi_mosi <= tx_init[DATA_WIDTH-1];
              tx_sr    <= tx_init << 1;
            end else begin
              tx_sr    <= tx_init;
            end
          end
        end
        SHIFT: begin
          if (half_end) begin
            spi_sclk <= ~spi_sclk;
            if (lead_edge ^ mode_q[0]) begin
              rx_sr <= {rx_sr[DATA_WIDTH-2:0], sample_bit};
            end else begin
              spi_mosi <= tx_sr[DATA_WIDTH-1];
              tx_sr    <= tx_sr << 1;
            end
            if (!lead_edge && bcnt != '0) bcnt <= bcnt - 1'b1;
          end
        end
        DONE: if (!hold_q) spi_cs_n <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
